// File: rtl/gate_test_pkg.sv
// Shared types and helpers for the quad 2-input gate vector tester.
// Holds the FSM state type, gate function codes and the expected-output function.
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] FUNC_AND  = 2'b00;
    localparam logic [1:0] FUNC_NAND = 2'b01;
    localparam logic [1:0] FUNC_OR   = 2'b10;
    localparam logic [1:0] FUNC_XOR  = 2'b11;

    function automatic logic gate_expect(input logic [1:0] func, input logic a, input logic b);
        logic y;
        case (func)
            FUNC_AND:  y = a & b;
            FUNC_NAND: y = ~(a & b);
            FUNC_OR:   y = a | b;
            default:   y = a ^ b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
// Each bit is synchronized on its own; no bus coherency is implied.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/quad_gate_vector_tester.sv
// Drives the 2-input truth table into a quad gate package and checks the returned outputs.
// Each vector is held SETTLE_CYCLES+1 cycles; the synchronized Y is compared in the last cycle.
module quad_gate_vector_tester #(
    parameter int unsigned NUM_GATES     = 4,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic [1:0]           FUNC_SEL,
    output logic [NUM_GATES-1:0] A,
    output logic [NUM_GATES-1:0] B,
    input  logic [NUM_GATES-1:0] Y,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [NUM_GATES-1:0] FAIL_GATE,
    output logic [1:0]           FAIL_VEC
);

    import gate_test_pkg::state_t;
    import gate_test_pkg::gate_expect;

    localparam int unsigned    CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES);

    state_t                 state;
    logic [1:0]             func;
    logic [1:0]             vec;
    logic [1:0]             vec_next;
    logic [CNT_W-1:0]       cnt;
    logic [NUM_GATES-1:0]   y_sync;
    logic [NUM_GATES-1:0]   expect_vec;
    logic [NUM_GATES-1:0]   mismatch;

    sync_2ff #(.WIDTH(NUM_GATES)) u_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (Y),
        .q     (y_sync)
    );

    always_comb begin
        expect_vec = {NUM_GATES{gate_expect(func, vec[1], vec[0])}};
        mismatch   = y_sync ^ expect_vec;
        vec_next   = vec + 2'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= gate_test_pkg::IDLE;
            func      <= '0;
            vec       <= '0;
            cnt       <= '0;
            A         <= '0;
            B         <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            FAIL_GATE <= '0;
            FAIL_VEC  <= '0;
        end else begin
            case (state)
                gate_test_pkg::IDLE, gate_test_pkg::DONE: begin
                    if (START) begin
                        state     <= gate_test_pkg::RUN;
                        func      <= FUNC_SEL;
                        vec       <= '0;
                        cnt       <= '0;
                        A         <= '0;
                        B         <= '0;
                        BUSY      <= 1'b1;
                        DONE      <= 1'b0;
                        PASS      <= 1'b0;
                        FAIL_GATE <= '0;
                        FAIL_VEC  <= '0;
                    end
                end
                gate_test_pkg::RUN: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        FAIL_GATE <= FAIL_GATE | mismatch;
                        // FAIL_GATE still empty means no earlier vector has failed
                        if (FAIL_GATE == '0 && mismatch != '0)
                            FAIL_VEC <= vec;
                        if (vec == 2'd3) begin
                            state <= gate_test_pkg::DONE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            PASS  <= ~|(FAIL_GATE | mismatch);
                            A     <= '0;
                            B     <= '0;
                        end else begin
                            vec <= vec_next;
                            A   <= {NUM_GATES{vec_next[1]}};
                            B   <= {NUM_GATES{vec_next[0]}};
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= gate_test_pkg::IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_gate_vector_tester.sv
// Self-checking bench: behavioural quad-gate chip with stuck-at faults, directed and random runs.
// Expected results come from truth-table constants evaluated per gate and vector.
module tb_quad_gate_vector_tester;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned HOLD    = SETTLE + 1;
    localparam int unsigned RUN_LEN = 4 * HOLD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] func_sel = 2'b00;
    logic [3:0] a_pins, b_pins, y_pins;
    logic       busy, done, pass;
    logic [3:0] fail_gate;
    logic [1:0] fail_vec;

    logic [1:0] chip = 2'b00;
    logic [3:0] sa0 = 4'h0;
    logic [3:0] sa1 = 4'h0;
    logic [3:0] chip_tt;

    int tests = 0;
    int failed = 0;

    quad_gate_vector_tester #(.NUM_GATES(4), .SETTLE_CYCLES(SETTLE)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .START     (start),
        .FUNC_SEL  (func_sel),
        .A         (a_pins),
        .B         (b_pins),
        .Y         (y_pins),
        .BUSY      (busy),
        .DONE      (done),
        .PASS      (pass),
        .FAIL_GATE (fail_gate),
        .FAIL_VEC  (fail_vec)
    );

    always #5 clk = ~clk;

    // Truth table indexed by {a,b}: AND, NAND, OR, XOR
    function automatic logic [3:0] tt(input logic [1:0] f);
        case (f)
            2'b00:   return 4'b1000;
            2'b01:   return 4'b0111;
            2'b10:   return 4'b1110;
            default: return 4'b0110;
        endcase
    endfunction

    always_comb begin
        chip_tt = tt(chip);
        y_pins  = '0;
        for (int i = 0; i < 4; i++)
            y_pins[i] = chip_tt[{a_pins[i], b_pins[i]}];
        y_pins = (y_pins & ~sa0) | sa1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_result(input logic [1:0] fsel, output logic [3:0] e_fail,
                                 output logic [1:0] e_vec);
        logic [3:0] et, ct, mm;
        logic       found;
        et = tt(fsel);
        ct = tt(chip);
        e_fail = '0;
        e_vec  = '0;
        found  = 1'b0;
        for (int v = 0; v < 4; v++) begin
            mm = '0;
            for (int g = 0; g < 4; g++)
                if (((ct[v] & ~sa0[g]) | sa1[g]) != et[v]) mm[g] = 1'b1;
            e_fail = e_fail | mm;
            if (mm != 0 && !found) begin
                e_vec = 2'(v);
                found = 1'b1;
            end
        end
    endtask

    // Called #1 after the accepting edge; walks one run and checks its result.
    task automatic run_body(input logic [1:0] fsel, input bit disturb, input bit hold);
        logic [3:0] e_fail;
        logic [1:0] e_vec;
        logic [1:0] vv;
        expect_result(fsel, e_fail, e_vec);
        check("start_busy", 32'(busy), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_fail_gate", 32'(fail_gate), 32'd0);
        check("start_fail_vec", 32'(fail_vec), 32'd0);
        for (int c = 1; c <= int'(RUN_LEN); c++) begin
            @(posedge clk);
            #1;
            if (disturb && c == 8) begin
                func_sel = ~fsel;
                start    = 1'b1;
            end
            if (disturb && c == 9) start = 1'b0;
            if (c < int'(RUN_LEN)) begin
                vv = 2'(c / int'(HOLD));
                check("vec_a", 32'(a_pins), vv[1] ? 32'hF : 32'h0);
                check("vec_b", 32'(b_pins), vv[0] ? 32'hF : 32'h0);
                check("run_done_low", 32'(done), 32'd0);
            end
        end
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_pass", 32'(pass), (e_fail == 0) ? 32'd1 : 32'd0);
        check("end_fail_gate", 32'(fail_gate), 32'(e_fail));
        check("end_fail_vec", 32'(fail_vec), 32'(e_vec));
        check("end_ab_zero", 32'({a_pins, b_pins}), 32'd0);
        if (!hold) begin
            @(posedge clk);
            #1;
            check("done_held", 32'(done), 32'd1);
            check("no_restart", 32'(busy), 32'd0);
        end
    endtask

    task automatic do_run(input logic [1:0] fsel, input bit disturb);
        @(negedge clk);
        func_sel = fsel;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        run_body(fsel, disturb, 1'b0);
    endtask

    initial begin
        #2;
        check("rst_state", 32'({a_pins, b_pins, busy, done, pass, fail_gate, fail_vec}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // good AND chip
        chip = 2'b00; sa0 = 4'h0; sa1 = 4'h0;
        do_run(2'b00, 1'b0);

        // gate 3 stuck-at-0
        sa0 = 4'b0100;
        do_run(2'b00, 1'b0);

        // NAND chip tested as AND
        chip = 2'b01; sa0 = 4'h0;
        do_run(2'b00, 1'b0);

        // XOR with mid-run disturbance
        chip = 2'b11;
        do_run(2'b11, 1'b1);

        // reset during vector 2
        chip = 2'b00;
        @(negedge clk);
        func_sel = 2'b00;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2 * HOLD + 1) @(posedge clk);
        #2;
        check("pre_rst_a", 32'(a_pins), 32'hF);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ab", 32'({a_pins, b_pins}), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_fail", 32'(fail_gate), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_run(2'b00, 1'b0);

        // START held high across two runs, gate 1 stuck-at-1
        sa1 = 4'b0001;
        @(negedge clk);
        func_sel = 2'b00;
        start    = 1'b1;
        @(posedge clk);
        #1;
        run_body(2'b00, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("restart_done_low", 32'(done), 32'd0);
        run_body(2'b00, 1'b0, 1'b1);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("hold_end_done", 32'(done), 32'd1);
        sa1 = 4'h0;

        // random chips, functions and faults
        for (int r = 0; r < 8; r++) begin
            chip = 2'($urandom_range(0, 3));
            sa0  = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            sa1  = ($urandom_range(0, 2) == 0) ? 4'($urandom) & ~sa0 : 4'h0;
            do_run(($urandom_range(0, 1) != 0) ? chip : 2'($urandom_range(0, 3)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
